// File: rtl/stream_pkg.sv
// Shared types and raster defaults for the pixel/blanking stream blocks.
// Used by the framer, the downsampler and the upsampler.
package stream_pkg;

  localparam int COUNT_W = 10;

  localparam int DEF_WIDTH         = 400;
  localparam int DEF_HEIGHT        = 300;
  localparam int DEF_H_BLANK       = 16;
  localparam int DEF_V_BLANK_LINES = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HBLANK,
    VBLANK
  } state_t;

endpackage

// File: rtl/framer_fifo.sv
// Synchronous input buffer for the blanking framer.
// Combinational read port; pointers wrap on the power-of-2 depth.
module framer_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q
            + {{AW{1'b0}}, do_push}
            - {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/blanking_framer.sv
// Buffers a bare valid-pixel stream and re-emits it as a raster
// with horizontal/vertical blanking beats and beat positions.
module blanking_framer
  import stream_pkg::*;
#(
  parameter int DW            = 8,
  parameter int WIDTH         = DEF_WIDTH,
  parameter int HEIGHT        = DEF_HEIGHT,
  parameter int H_BLANK       = DEF_H_BLANK,
  parameter int V_BLANK_LINES = DEF_V_BLANK_LINES,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [DW-1:0]      din,
  input  logic               valid,
  output logic               ready,
  output logic [DW-1:0]      dout,
  output logic               blankingregion,
  output logic               validout,
  output logic [COUNT_W-1:0] rowcount,
  output logic [COUNT_W-1:0] colcount,
  output logic               overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [COUNT_W-1:0] LAST_ACT  =
    COUNT_W'(WIDTH - 1);
  localparam logic [COUNT_W-1:0] LAST_COL  =
    COUNT_W'(WIDTH + H_BLANK - 1);
  localparam logic [COUNT_W-1:0] LAST_AROW =
    COUNT_W'(HEIGHT - 1);
  localparam logic [COUNT_W-1:0] LAST_ROW  =
    COUNT_W'(HEIGHT + V_BLANK_LINES - 1);

  if (WIDTH + H_BLANK > 1024 ||
      HEIGHT + V_BLANK_LINES > 1024 ||
      H_BLANK < 1 || FIFO_DEPTH < 2 ||
      (1 << AW) != FIFO_DEPTH) begin : g_bad_params
    $error("blanking_framer: illegal parameters");
  end

  logic [DW-1:0] fifo_dout;
  logic [AW:0]   fifo_count;
  logic          fifo_full, fifo_empty, push, pop;

  state_t               state_q, state_d;
  logic [COUNT_W-1:0]   row_q, row_d, col_q, col_d;
  logic                 overflow_q, overflow_d;

  logic                 beat_valid, beat_blank;
  logic [DW-1:0]        beat_data;

  logic                 s1_valid_q, s1_blank_q;
  logic [DW-1:0]        s1_data_q;
  logic [COUNT_W-1:0]   s1_row_q, s1_row_d;
  logic [COUNT_W-1:0]   s1_col_q, s1_col_d;

  logic                 validout_q, blank_q;
  logic [DW-1:0]        dout_q;
  logic [COUNT_W-1:0]   rowcount_q, colcount_q;

  assign ready = reset & (fifo_count < (AW+1)'(FIFO_DEPTH));
  assign push  = valid & ready;

  framer_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    pop        = 1'b0;
    beat_valid = 1'b0;
    beat_blank = 1'b0;
    beat_data  = '0;
    unique case (state_q)
      IDLE, ACTIVE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          beat_valid = 1'b1;
          beat_data  = fifo_dout;
          col_d      = col_q + COUNT_W'(1);
          state_d    = (col_q == LAST_ACT) ? HBLANK : ACTIVE;
        end
      end
      HBLANK: begin
        beat_valid = 1'b1;
        beat_blank = 1'b1;
        col_d      = col_q + COUNT_W'(1);
        if (col_q == LAST_COL) begin
          col_d   = '0;
          row_d   = row_q + COUNT_W'(1);
          state_d = (row_q == LAST_AROW) ? VBLANK : ACTIVE;
        end
      end
      VBLANK: begin
        beat_valid = 1'b1;
        beat_blank = 1'b1;
        col_d      = col_q + COUNT_W'(1);
        if (col_q == LAST_COL) begin
          col_d = '0;
          row_d = row_q + COUNT_W'(1);
          if (row_q == LAST_ROW) begin
            row_d   = '0;
            state_d = fifo_empty ? IDLE : ACTIVE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat position holds across bubbles so consumers see the last one.
  always_comb begin
    s1_row_d   = beat_valid ? row_q : s1_row_q;
    s1_col_d   = beat_valid ? col_q : s1_col_q;
    overflow_d = overflow_q | (valid & fifo_full);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      overflow_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_blank_q <= 1'b0;
      s1_data_q  <= '0;
      s1_row_q   <= '0;
      s1_col_q   <= '0;
      validout_q <= 1'b0;
      blank_q    <= 1'b0;
      dout_q     <= '0;
      rowcount_q <= '0;
      colcount_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      overflow_q <= overflow_d;
      s1_valid_q <= beat_valid;
      s1_blank_q <= beat_blank;
      s1_data_q  <= beat_data;
      s1_row_q   <= s1_row_d;
      s1_col_q   <= s1_col_d;
      validout_q <= s1_valid_q;
      blank_q    <= s1_blank_q;
      dout_q     <= s1_data_q;
      rowcount_q <= s1_row_q;
      colcount_q <= s1_col_q;
    end
  end

  assign dout           = dout_q;
  assign blankingregion = blank_q;
  assign validout       = validout_q;
  assign rowcount       = rowcount_q;
  assign colcount       = colcount_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_blanking_framer.sv
// Directed bench for blanking_framer on a 4x2 raster,
// 2 h-blank beats, 1 v-blank line, 4-entry buffer.
module tb_blanking_framer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] din   = '0;
  logic       ready, blankingregion, validout, overflow;
  logic [7:0] dout;
  logic [9:0] rowcount, colcount;

  int checks  = 0;
  int errors  = 0;
  int sent    = 0;
  int exp_pix = 1;
  bit honour  = 1'b1;

  int t4_v [14] = '{1,1,0,0,0,0,0,1,1,1,1,0,0,0};
  int t4_c [14] = '{0,1,1,1,1,1,1,2,3,4,5,5,5,5};

  blanking_framer #(
    .DW            (8),
    .WIDTH         (4),
    .HEIGHT        (2),
    .H_BLANK       (2),
    .V_BLANK_LINES (1),
    .FIFO_DEPTH    (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .din            (din),
    .valid          (valid),
    .ready          (ready),
    .dout           (dout),
    .blankingregion (blankingregion),
    .validout       (validout),
    .rowcount       (rowcount),
    .colcount       (colcount),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    valid = 1'b0;
    din   = '0;
    repeat (3) tick();
  endtask

  task automatic release_reset();
    reset   = 1'b1;
    sent    = 0;
    exp_pix = 1;
    #1;
  endtask

  task automatic cycle(input bit want);
    bit acc;
    valid = want && (ready || !honour);
    din   = ready ? 8'(sent + 1) : 8'hEE;
    acc   = valid && ready;
    tick();
    if (acc) sent++;
    if (validout && !blankingregion) begin
      chk("order", 32'(dout), 32'(exp_pix));
      exp_pix++;
    end
  endtask

  initial begin
    int k, r, c, bl, d;

    // 1: one full frame from pixels 1..8
    hold_reset();
    chk("rst_v", 32'(validout), 0);
    chk("rst_d", 32'(dout), 0);
    chk("rst_b", 32'(blankingregion), 0);
    chk("rst_r", 32'(rowcount), 0);
    chk("rst_c", 32'(colcount), 0);
    chk("rst_o", 32'(overflow), 0);
    chk("rst_rdy", 32'(ready), 0);
    release_reset();
    honour = 1'b1;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      cycle(cyc <= 8);
      if (cyc >= 3 && cyc <= 20) begin
        k  = cyc - 3;
        r  = k / 6;
        c  = k % 6;
        bl = (c >= 4 || r == 2) ? 1 : 0;
        d  = bl ? 0 : r * 4 + c + 1;
        chk("t1_v", 32'(validout), 1);
        chk("t1_r", 32'(rowcount), 32'(r));
        chk("t1_c", 32'(colcount), 32'(c));
        chk("t1_b", 32'(blankingregion), 32'(bl));
        chk("t1_d", 32'(dout), 32'(d));
      end else begin
        chk("t1_idle", 32'(validout), 0);
      end
    end
    chk("t1_cnt", 32'(exp_pix), 9);

    // 2: backpressure with a well-behaved source
    hold_reset();
    release_reset();
    for (int cyc = 1; cyc <= 40; cyc++) begin
      cycle(sent < 12);
      if (cyc == 11) chk("t2_rdy_hi", 32'(ready), 1);
      if (cyc == 12) chk("t2_rdy_lo", 32'(ready), 0);
    end
    chk("t2_sent", 32'(sent), 12);
    chk("t2_cnt", 32'(exp_pix), 13);
    chk("t2_ovf", 32'(overflow), 0);

    // 3: source ignores ready
    hold_reset();
    release_reset();
    honour = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      cycle(cyc <= 14);
      if (cyc == 12) chk("t3_ovf0", 32'(overflow), 0);
      if (cyc == 13) chk("t3_ovf1", 32'(overflow), 1);
    end
    chk("t3_sticky", 32'(overflow), 1);
    chk("t3_cnt", 32'(exp_pix), 13);
    honour = 1'b1;

    // 4: starvation gap inside a line
    hold_reset();
    release_reset();
    for (int cyc = 1; cyc <= 16; cyc++) begin
      cycle(cyc == 1 || cyc == 2 || cyc == 8 || cyc == 9);
      if (cyc >= 3) begin
        chk("t4_v", 32'(validout), 32'(t4_v[cyc-3]));
        chk("t4_c", 32'(colcount), 32'(t4_c[cyc-3]));
        chk("t4_r", 32'(rowcount), 0);
      end
    end
    chk("t4_cnt", 32'(exp_pix), 5);

    // 5: reset in the middle of row 1
    hold_reset();
    release_reset();
    for (int cyc = 1; cyc <= 11; cyc++) cycle(cyc <= 8);
    chk("t5_r", 32'(rowcount), 1);
    chk("t5_c", 32'(colcount), 2);
    chk("t5_d", 32'(dout), 7);
    reset = 1'b0;
    #1;
    chk("t5_rdy0", 32'(ready), 0);
    tick();
    chk("t5_v0", 32'(validout), 0);
    chk("t5_d0", 32'(dout), 0);
    chk("t5_b0", 32'(blankingregion), 0);
    chk("t5_r0", 32'(rowcount), 0);
    chk("t5_c0", 32'(colcount), 0);
    chk("t5_rdy", 32'(ready), 0);
    release_reset();
    sent    = 8;
    exp_pix = 9;
    cycle(1'b1);
    cycle(1'b0);
    chk("t5_lat", 32'(validout), 0);
    cycle(1'b0);
    chk("t5_v9", 32'(validout), 1);
    chk("t5_d9", 32'(dout), 9);
    chk("t5_r9", 32'(rowcount), 0);
    chk("t5_c9", 32'(colcount), 0);

    // 6: back-to-back frames
    hold_reset();
    release_reset();
    for (int cyc = 1; cyc <= 40; cyc++) begin
      cycle(sent < 16);
      if (cyc == 20) begin
        chk("t6_lv", 32'(validout), 1);
        chk("t6_lb", 32'(blankingregion), 1);
        chk("t6_lr", 32'(rowcount), 2);
        chk("t6_lc", 32'(colcount), 5);
      end
      if (cyc == 21) begin
        chk("t6_fv", 32'(validout), 1);
        chk("t6_fb", 32'(blankingregion), 0);
        chk("t6_fr", 32'(rowcount), 0);
        chk("t6_fc", 32'(colcount), 0);
        chk("t6_fd", 32'(dout), 9);
      end
    end
    chk("t6_cnt", 32'(exp_pix), 17);
    chk("t6_ovf", 32'(overflow), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/blanking_framer.md
Name: blanking_framer

Overview:
- Transmit side of the pixel/blanking stream protocol (dout, blankingregion, validout) consumed by the 5x5 window and upsampler path.
- Accepts a gapless stream of valid downsampled pixels, buffers them, and re-emits them as a framed raster.
- Inserts explicit horizontal and vertical blanking beats and reports the raster position of every output beat.
- Single clock domain; sits after any block that produces bare valid pixels (e.g. filter outputs) and feeds blanking-aware consumers.

Parameters:
- DW, 8, pixel width in bits.
- WIDTH, 400, active pixels per line.
- HEIGHT, 300, active lines per frame.
- H_BLANK, 16, blanking beats appended after each line (active or blank line).
- V_BLANK_LINES, 2, full blank lines after the last active line.
- FIFO_DEPTH, 16, input buffer entries, power of 2, ≥2.

Ports:
- clock  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-low (0 = reset).
- din  in  DW  input pixel.
- valid  in  1  din is valid this cycle.
- ready  out  1  buffer can accept; a pixel is accepted only when valid && ready.
- dout  out  DW  output pixel; 0 during blanking or idle.
- blankingregion  out  1  current output beat is blanking.
- validout  out  1  output beat valid (pixel or blanking).
- rowcount  out  10  raster row of the current beat, 0..HEIGHT+V_BLANK_LINES-1.
- colcount  out  10  raster column of the current beat, 0..WIDTH+H_BLANK-1.
- overflow  out  1  sticky: valid seen while ready=0.

Behaviour:
- Reset (reset=0 at an edge): FIFO flushed, FSM to IDLE, counters 0, overflow 0. Registered outputs dout/blankingregion/validout/rowcount/colcount become 0 after that edge. ready is 0 while reset=0. Reset mid-frame abandons the frame with no partial flush.
- ready = (fifo count < FIFO_DEPTH) and not in reset. Write on valid && ready. valid && !ready sets overflow; the pixel is dropped. overflow is cleared only by reset.
- All stream outputs are registered. With an empty FIFO in IDLE/ACTIVE, a pixel accepted at edge t appears on dout with validout=1 after edge t+2 (latency 2).
- FSM states:
  - IDLE: validout=0. Go to ACTIVE when the FIFO is non-empty; row=col=0.
  - ACTIVE: each cycle with the FIFO non-empty, pop and emit a beat (validout=1, blankingregion=0, dout=pixel, colcount=col), then col++. FIFO empty → bubble (validout=0, counters hold). After emitting col=WIDTH-1, go to HBLANK with col=WIDTH.
  - HBLANK: emit H_BLANK beats (validout=1, blankingregion=1, dout=0), col increments. After col=WIDTH+H_BLANK-1: col=0, row++. Next state: ACTIVE if row+1<HEIGHT; else VBLANK.
  - VBLANK: emit V_BLANK_LINES*(WIDTH+H_BLANK) beats, blankingregion=1, validout=1, never stalls, col/row wrap as a raster. After the last beat (row=HEIGHT+V_BLANK_LINES-1, col=WIDTH+H_BLANK-1): row=col=0, go to ACTIVE if the FIFO is non-empty, else IDLE.
- HBLANK/VBLANK never pop; input may keep filling the FIFO during blanking.
- Simultaneous push and pop when full: not possible, since ready=0 at full. Simultaneous push and pop otherwise: count unchanged.
- Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
- Legal range: WIDTH+H_BLANK ≤ 1024 and HEIGHT+V_BLANK_LINES ≤ 1024 (elaboration check); H_BLANK ≥ 1.

Decomposition:
- Shared package (stream_pkg):
  - state enum IDLE/ACTIVE/HBLANK/VBLANK;
  - COUNT_W=10;
  - default raster constants (400x300, 16, 2) shared with the downsampler and upsampler.
- Sub-module framer_fifo: synchronous FIFO (DW, FIFO_DEPTH) with push, pop, dout, count, full, empty. Same clock and active-low synchronous reset.

Test Plan:
(bench params WIDTH=4, HEIGHT=2, H_BLANK=2, V_BLANK_LINES=1, FIFO_DEPTH=4)
1. Reset held 3 cycles, then valid pixels 1..8 back-to-back. Required output:
   - first beat dout=1, col=0, row=0, two cycles after the first accept;
   - cols 4,5 blanking;
   - row 1 carries pixels 5..8;
   - row 2 has 6 blanking beats;
   - ends in IDLE with validout=0.
2. Backpressure: 12 pixels offered continuously. ready drops at count=4 during HBLANK, no pixel is lost, overflow stays 0 when the source honours ready.
3. Overflow: valid held high while ready=0 → overflow=1 and stays 1. The dropped pixel never appears on dout.
4. Starvation: pixels 1,2 fed, then a 5-cycle gap, then pixels 3,4. Output: beats col 0,1, then validout=0 for the gap with counters held, then col 2,3, then HBLANK.
5. Mid-frame reset: reset=0 during row 1, col 2. The next cycle shows all outputs 0 and ready=0. After release, new pixel 9 emits at row=0, col=0.
6. Back-to-back frames: 16 pixels fed continuously. Frame 2 starts ACTIVE directly after the last VBLANK beat (no IDLE cycle) with row=0, col=0, dout=9.
